// File: rtl/sd_otf_converter_pkg.sv
// Shared BKM definitions: signed-digit encodings and converter FSM states.
package sd_otf_converter_pkg;

    localparam logic [1:0] SD_POS  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_NEG  = 2'b11;
    localparam logic [1:0] SD_ILL  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } otf_state_t;

endpackage

// File: rtl/sd_otf_converter.sv
// On-the-fly conversion of an MSB-first radix-2 signed-digit stream to two's complement,
// using the Q/QM register pair so no carry-propagate adder is needed.
module sd_otf_converter
    import sd_otf_converter_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              in_valid,
    input  logic [1:0]        in_d,
    output logic              in_ready,
    output logic              out_valid,
    output logic signed [W:0] out_q,
    output logic              out_err,
    input  logic              out_ready
);

    otf_state_t        state, state_nxt;
    logic signed [W:0] q, qm;
    logic signed [W:0] q_base, qm_base, q_nxt, qm_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              err, err_base, err_nxt;
    logic              accept, last_digit, leave_hold;

    assign in_ready   = (state != ST_HOLD);
    assign out_valid  = (state == ST_HOLD);
    assign accept     = in_valid & in_ready & ena;
    assign leave_hold = (state == ST_HOLD) & out_ready & ena;
    assign last_digit = (state == ST_IDLE) ? (W == 1) : (cnt == CNT_W'(W - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else if (ena)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ACC: if (accept) state_nxt = last_digit ? ST_HOLD : ST_ACC;
            ST_HOLD:         if (out_ready) state_nxt = ST_IDLE;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    // The first digit of a word always starts from Q=0, QM=-1, independent of leftovers.
    always_comb begin
        q_base   = (state == ST_IDLE) ? '0 : q;
        qm_base  = (state == ST_IDLE) ? '1 : qm;
        err_base = (state == ST_IDLE) ? 1'b0 : err;
        err_nxt  = err_base | (in_d == SD_ILL);
        case (in_d)
            SD_POS: begin
                q_nxt  = {q_base[W-1:0], 1'b1};
                qm_nxt = {q_base[W-1:0], 1'b0};
            end
            SD_NEG: begin
                q_nxt  = {qm_base[W-1:0], 1'b1};
                qm_nxt = {qm_base[W-1:0], 1'b0};
            end
            default: begin
                q_nxt  = {q_base[W-1:0], 1'b0};
                qm_nxt = {qm_base[W-1:0], 1'b1};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            qm      <= '1;
            err     <= 1'b0;
            cnt     <= '0;
            out_q   <= '0;
            out_err <= 1'b0;
        end else if (accept) begin
            q   <= q_nxt;
            qm  <= qm_nxt;
            err <= err_nxt;
            cnt <= (state == ST_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
            if (last_digit) begin
                out_q   <= q_nxt;
                out_err <= err_nxt;
            end
        end else if (leave_hold) begin
            q   <= '0;
            qm  <= '1;
            err <= 1'b0;
            cnt <= '0;
        end
    end

endmodule
